mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported 64-bit unified memory between the pipelined CPU's fetch stage (IF) and memory stage (MEM). It serialises accesses through a small state machine and applies a configurable fixed access latency. It returns read data to the winner and drives the stall signals the pipeline registers use to hold while an access is pending. Data accesses take priority over fetches, and a streak counter bounds fetch starvation.

## Interface
- LAT, 2: memory access latency in cycles, from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- MAX_STREAK, 3: number of consecutive contested data grants after which a pending fetch wins; legal range 1..7.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- if_req  in  1  fetch request; level, held until if_gnt.
- if_addr  in  64  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  one-cycle pulse; fetch complete, if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; level, held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  data byte address; bits [2:0] ignored.
- d_wdata  in  64  store data.
- d_gnt  out  1  one-cycle pulse; data access complete.
- d_rdata  out  64  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  doubleword-aligned address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data; valid LAT-1 cycles after the mem_en cycle.
- stall_if  out  1  if_req & ~if_gnt.
- stall_all  out  1  d_req & ~d_gnt.

## Operation
- States: IDLE, BUSY_I, BUSY_D. A 4-bit down-counter cnt and a 3-bit streak counter are also held.
- IDLE, rising edge:
  - d_req only: go to BUSY_D.
  - if_req only: go to BUSY_I.
  - Both pending and streak == MAX_STREAK: go to BUSY_I.
  - Both pending otherwise: go to BUSY_D.
  - Neither pending: stay in IDLE.
- On entering BUSY: latch the address, we and wdata of the winner into output registers, and load cnt = LAT-1.
- mem_en is 1 only in the first BUSY cycle. mem_we = latched d_we & mem_en; mem_we is always 0 for fetches.
- mem_addr = {latched addr[63:3], 3'b000}. mem_wdata = latched d_wdata, or 0 for fetches.
- BUSY with cnt != 0: decrement cnt. BUSY with cnt == 0 (the done cycle):
  - Assert the matching gnt combinationally.
  - Pass the read data through:
    - if_rdata = latched if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
    - d_rdata = mem_rdata for loads, 0 for stores.
  - Return to IDLE at the next edge.
- if_rdata and d_rdata are 0 whenever their gnt is 0.
- Streak counter:
  - Increments, saturating at MAX_STREAK, on each BUSY_D entry made while if_req was also 1.
  - Clears on BUSY_I entry.
  - Unchanged on an uncontested BUSY_D entry.
- A request that drops mid-transaction does not abort it. The gnt still pulses and the requester ignores it.

## Timing
- Request sampled at edge E0 in IDLE. mem_en is high in cycle E0+1. gnt is high in cycle E0+LAT.
- FSM is back in IDLE at E0+LAT+1. Back-to-back accesses therefore occupy LAT+1 cycles each, with one forced IDLE cycle between them.
- LAT=1: mem_en and gnt are asserted in the same single BUSY cycle.
- A requester must deassert or change its request at the edge following its gnt. The forced IDLE cycle guarantees a stale request is never re-granted.
- Reset asserted, including mid-transaction:
  - Immediately forces IDLE, cnt = 0, streak = 0, and all registered outputs to 0 (mem_en, mem_we, mem_addr, mem_wdata).
  - if_gnt, d_gnt, if_rdata and d_rdata go to 0.
  - The in-flight access is dropped without a gnt. Requesters still holding req are re-arbitrated on the first edge after reset deasserts.
- stall_if and stall_all are combinational and follow req immediately. They stay 1 through the IDLE arbitration cycle and 0 only in the gnt cycle.

## Test plan
- Lone fetch, LAT=2: if_req=1, if_addr=0x104 at edge E0, memory returns 0xAAAA_BBBB_1111_2222 -> mem_en at E0+1 with mem_addr=0x100; if_gnt at E0+2 with if_rdata=0xAAAA_BBBB; stall_if=1 until then.
- Store then load: store d_addr=0x20, d_wdata=0xDEAD_BEEF_0000_0001 -> mem_we=1 only in the mem_en cycle and d_rdata=0 at d_gnt. Then load 0x20 -> d_rdata=0xDEAD_BEEF_0000_0001 at d_gnt.
- Contention, MAX_STREAK=3: if_req held and d_req re-asserted after each grant -> grant order D,D,D,I,D,D,D,I; streak returns to 0 after each I.
- LAT=1: single fetch -> mem_en and if_gnt in the same cycle; the next grant comes no earlier than two cycles later.
- Reset mid-operation: reset driven low in the second BUSY_D cycle of a LAT=3 load -> no d_gnt, all outputs 0 at once; after release with d_req still held, mem_en reasserts one edge later.
- Request withdrawn: d_req dropped in the first BUSY_D cycle -> d_gnt still pulses at E0+LAT, then FSM returns to IDLE and issues no further mem_en.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported 64-bit memory between the CPU fetch stage (IF)
// and memory stage (MEM). Accesses are serialised: one access is in flight
// at a time, and each takes LAT cycles from the mem_en cycle to the grant
// cycle. Data requests beat fetch requests. However, once MAX_STREAK
// consecutive contested data grants have gone by, a waiting fetch wins the
// next arbitration so it cannot starve.
//
// Parameters
//   LAT         memory latency, mem_en cycle to mem_rdata-valid cycle (1..15)
//   MAX_STREAK  contested data grants before a pending fetch wins (1..7)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   if_req     fetch request, level, held until if_gnt
//   if_addr    fetch byte address; bit 2 selects the instruction word
//   if_gnt     one-cycle pulse, fetch complete, if_rdata valid
//   if_rdata   fetched instruction, zero when if_gnt is low
//   d_req      data request, level, held until d_gnt
//   d_we       1 = store, 0 = load
//   d_addr     data byte address, doubleword granularity
//   d_wdata    store data
//   d_gnt      one-cycle pulse, data access complete
//   d_rdata    load data, zero for stores and when d_gnt is low
//   mem_en     memory strobe, first BUSY cycle only
//   mem_we     memory write enable, qualified by mem_en
//   mem_addr   doubleword-aligned memory address (registered)
//   mem_wdata  memory write data (registered, zero for fetches)
//   mem_rdata  memory read data, valid LAT-1 cycles after mem_en
//   stall_if   fetch stage hold: if_req & ~if_gnt
//   stall_all  pipeline hold:    d_req & ~d_gnt
//
// state  | meaning
// IDLE   | no access in flight; arbitrate on the next edge
// BUSY_I | fetch access in flight; cnt counts down to the grant cycle
// BUSY_D | data access in flight; cnt counts down to the grant cycle

module mem_port_arbiter #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_all
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD   = 4'(LAT - 1);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] streak;
  logic       lat_we;
  logic       lat_hi_word;

  // Byte-offset bits below the selected word / doubleword carry no meaning.
  logic       unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[2:0]};

  // A fetch only wins a contested arbitration once the data streak has
  // reached its limit; a lone request always wins.
  logic       pick_d;
  assign pick_d = d_req && (!if_req || (streak != STREAK_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      streak      <= 3'd0;
      lat_we      <= 1'b0;
      lat_hi_word <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
    end else begin
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= BUSY_D;
            cnt         <= CNT_LOAD;
            mem_en      <= 1'b1;
            lat_we      <= d_we;
            lat_hi_word <= 1'b0;
            mem_addr    <= {d_addr[63:3], 3'b000};
            mem_wdata   <= d_wdata;
            // Only contested data wins extend the streak. pick_d with
            // if_req set implies streak < STREAK_MAX, so this saturates.
            if (if_req) begin
              streak <= streak + 3'd1;
            end
          end else if (if_req) begin
            state       <= BUSY_I;
            cnt         <= CNT_LOAD;
            mem_en      <= 1'b1;
            lat_we      <= 1'b0;
            lat_hi_word <= if_addr[2];
            mem_addr    <= {if_addr[63:3], 3'b000};
            mem_wdata   <= 64'd0;
            streak      <= 3'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          // The grant cycle is followed by a forced IDLE cycle, so a
          // request still high at the next edge is never re-granted.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we = lat_we & mem_en;

  // Grants are decoded from state so an asynchronous reset removes them
  // in the same instant it drops the in-flight access.
  assign if_gnt = (state == BUSY_I) && (cnt == 4'd0);
  assign d_gnt  = (state == BUSY_D) && (cnt == 4'd0);

  assign if_rdata = if_gnt ? (lat_hi_word ? mem_rdata[63:32] : mem_rdata[31:0])
                           : 32'd0;
  assign d_rdata  = (d_gnt && !lat_we) ? mem_rdata : 64'd0;

  assign stall_if  = if_req & ~if_gnt;
  assign stall_all = d_req & ~d_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic [63:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall_if;
  logic        stall_all;

  logic        l1_if_req;
  logic [63:0] l1_if_addr;
  logic        l1_if_gnt;
  logic [31:0] l1_if_rdata;
  logic        l1_d_req;
  logic        l1_d_we;
  logic [63:0] l1_d_addr;
  logic [63:0] l1_d_wdata;
  logic        l1_d_gnt;
  logic [63:0] l1_d_rdata;
  logic        l1_mem_en;
  logic        l1_mem_we;
  logic [63:0] l1_mem_addr;
  logic [63:0] l1_mem_wdata;
  logic [63:0] l1_mem_rdata;
  logic        l1_stall_if;
  logic        l1_stall_all;

  mem_port_arbiter #(.LAT(LAT), .MAX_STREAK(MAXS)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_all(stall_all)
  );

  mem_port_arbiter #(.LAT(1), .MAX_STREAK(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rdata(l1_if_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_gnt(l1_d_gnt), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .stall_if(l1_stall_if), .stall_all(l1_stall_all)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Memory responder: data only appears LAT-1 cycles after a strobe.
  logic [63:0] tb_mem  [16];
  logic [63:0] ref_mem [16];
  logic        hist_en [16];
  logic [3:0]  hist_idx[16];

  task automatic mem_step();
    for (int k = 15; k > 0; k--) begin
      hist_en[k]  = hist_en[k-1];
      hist_idx[k] = hist_idx[k-1];
    end
    hist_en[0]  = mem_en;
    hist_idx[0] = mem_addr[6:3];
    if (mem_en && mem_we) tb_mem[mem_addr[6:3]] = mem_wdata;
    if (hist_en[LAT-1]) mem_rdata = tb_mem[hist_idx[LAT-1]];
    else                mem_rdata = {$urandom, $urandom};
  endtask

  // Transaction-level reference: one access at a time, timed from the
  // arbitration edge number.
  int          now_edge = 0;
  bit          m_busy   = 0;
  bit          m_data   = 0;
  bit          m_we     = 0;
  logic [63:0] m_addr   = '0;
  logic [63:0] m_wdata  = '0;
  int          m_e0     = 0;
  int          m_streak = 0;

  bit f_done = 0, d_done = 0, d_wd = 0;
  int run = 0;
  bit seen_fetch = 0;

  task automatic start_fetch();
    m_busy = 1; m_data = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
    m_e0 = now_edge; m_streak = 0;
  endtask

  task automatic start_data();
    m_busy = 1; m_data = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
    m_e0 = now_edge;
  endtask

  task automatic model_edge();
    now_edge++;
    if (!m_busy) begin
      if (d_req && if_req) begin
        if (m_streak == MAXS) start_fetch();
        else begin
          start_data();
          m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
        end
      end else if (d_req) start_data();
      else if (if_req) start_fetch();
    end else if (now_edge >= m_e0 + LAT) begin
      m_busy = 0;
    end
  endtask

  task automatic agents(input int mode);
    if (f_done) begin f_done = 0; if_req = 0; end
    if (!if_req && (mode == 1 || $urandom_range(0, 3) == 0)) begin
      if_req  = 1;
      if_addr = {$urandom, $urandom};
    end
    if (d_done) begin d_done = 0; d_wd = 0; d_req = 0; end
    if (!d_req && !d_wd && (mode == 1 || $urandom_range(0, 2) == 0)) begin
      d_req   = 1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
    end else if (mode == 0 && d_req && m_busy && m_data &&
                 now_edge < m_e0 + LAT - 1 && $urandom_range(0, 15) == 0) begin
      d_req = 0;
      d_wd  = 1;
    end
  endtask

  task automatic check_reset();
    check_val("rst_mem_en", mem_en, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_if_gnt", if_gnt, 0);
    check_val("rst_d_gnt", d_gnt, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    check_val("rst_d_rdata", d_rdata, 0);
    check_val("rst_stall_if", stall_if, if_req);
    check_val("rst_stall_all", stall_all, d_req);
  endtask

  task automatic check_cycle(input int mode);
    bit          exp_en, exp_gnt, exp_ig, exp_dg;
    logic [3:0]  idx;
    logic [63:0] word;
    logic [31:0] exp_ir;
    logic [63:0] exp_dr;
    exp_en  = m_busy && (now_edge == m_e0);
    exp_gnt = m_busy && (now_edge == m_e0 + LAT - 1);
    exp_ig  = exp_gnt && !m_data;
    exp_dg  = exp_gnt && m_data;
    idx     = m_addr[6:3];
    word    = ref_mem[idx];
    exp_ir  = exp_ig ? (m_addr[2] ? word[63:32] : word[31:0]) : 32'd0;
    exp_dr  = (exp_dg && !m_we) ? word : 64'd0;
    check_val("if_gnt", if_gnt, exp_ig);
    check_val("d_gnt", d_gnt, exp_dg);
    check_val("mem_en", mem_en, exp_en);
    check_val("mem_we", mem_we, exp_en && m_we);
    check_val("stall_if", stall_if, if_req && !exp_ig);
    check_val("stall_all", stall_all, d_req && !exp_dg);
    check_val("if_rdata", if_rdata, exp_ir);
    check_val("d_rdata", d_rdata, exp_dr);
    if (exp_en) begin
      check_val("mem_addr", mem_addr, {m_addr[63:3], 3'b000});
      check_val("mem_wdata", mem_wdata, m_wdata);
      if (m_data && m_we) ref_mem[idx] = m_wdata;
    end
    if (exp_ig) f_done = 1;
    if (exp_dg) d_done = 1;
    // Under permanent contention every fetch grant follows exactly MAXS data grants.
    if (mode == 1) begin
      if (d_gnt) run++;
      if (if_gnt) begin
        if (seen_fetch) check_val("streak_run", 64'(run), 64'(MAXS));
        seen_fetch = 1;
        run = 0;
      end
    end
  endtask

  task automatic lat1_test();
    @(negedge clk);
    l1_if_req = 1; l1_if_addr = 64'h104; l1_mem_rdata = 64'hAAAA_BBBB_1111_2222;
    #1 check_val("l1_idle_stall_if", l1_stall_if, 1);
    check_val("l1_idle_mem_en", l1_mem_en, 0);
    @(negedge clk); #1;
    check_val("l1_f_mem_en", l1_mem_en, 1);
    check_val("l1_f_gnt", l1_if_gnt, 1);
    check_val("l1_f_addr", l1_mem_addr, 64'h100);
    check_val("l1_f_rdata", l1_if_rdata, 32'hAAAA_BBBB);
    check_val("l1_f_stall", l1_stall_if, 0);
    check_val("l1_f_we", l1_mem_we, 0);
    @(negedge clk);
    l1_if_addr = 64'h8;
    #1 check_val("l1_gap_mem_en", l1_mem_en, 0);
    check_val("l1_gap_gnt", l1_if_gnt, 0);
    check_val("l1_gap_rdata", l1_if_rdata, 0);
    check_val("l1_gap_stall", l1_stall_if, 1);
    @(negedge clk); #1;
    check_val("l1_f2_gnt", l1_if_gnt, 1);
    check_val("l1_f2_rdata", l1_if_rdata, 32'h1111_2222);
    check_val("l1_f2_addr", l1_mem_addr, 64'h8);
    @(negedge clk);
    l1_if_addr = 64'h10;
    l1_d_req = 1; l1_d_we = 1; l1_d_addr = 64'h2F; l1_d_wdata = 64'h55;
    @(negedge clk); #1;
    check_val("l1_st_gnt", l1_d_gnt, 1);
    check_val("l1_st_if_gnt", l1_if_gnt, 0);
    check_val("l1_st_we", l1_mem_we, 1);
    check_val("l1_st_addr", l1_mem_addr, 64'h28);
    check_val("l1_st_wdata", l1_mem_wdata, 64'h55);
    check_val("l1_st_rdata", l1_d_rdata, 0);
    check_val("l1_st_stall_if", l1_stall_if, 1);
    @(negedge clk);
    l1_d_we = 0; l1_d_addr = 64'h30;
    #1 check_val("l1_gap2_d_gnt", l1_d_gnt, 0);
    @(negedge clk); #1;
    check_val("l1_fw_if_gnt", l1_if_gnt, 1);
    check_val("l1_fw_d_gnt", l1_d_gnt, 0);
    check_val("l1_fw_stall_all", l1_stall_all, 1);
    check_val("l1_fw_rdata", l1_if_rdata, 32'h1111_2222);
    check_val("l1_fw_wdata", l1_mem_wdata, 0);
    @(negedge clk);
    l1_if_req = 0;
    @(negedge clk); #1;
    check_val("l1_ld_gnt", l1_d_gnt, 1);
    check_val("l1_ld_rdata", l1_d_rdata, 64'hAAAA_BBBB_1111_2222);
    check_val("l1_ld_we", l1_mem_we, 0);
    check_val("l1_ld_addr", l1_mem_addr, 64'h30);
    @(negedge clk);
    l1_d_req = 0;
  endtask

  initial begin
    bit rst_now;
    int mode;
    reset = 0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    l1_if_req = 0; l1_if_addr = '0; l1_d_req = 0; l1_d_we = 0; l1_d_addr = '0;
    l1_d_wdata = '0; l1_mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]   = {$urandom, $urandom};
      ref_mem[i]  = tb_mem[i];
      hist_en[i]  = 0;
      hist_idx[i] = '0;
    end
    @(negedge clk); @(negedge clk);
    #1 check_reset();
    check_val("rst_l1_mem_en", l1_mem_en, 0);
    check_val("rst_l1_if_gnt", l1_if_gnt, 0);
    @(negedge clk);
    reset = 1;
    lat1_test();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      mode = (cyc >= 2000 && cyc < 2600) ? 1 : 0;
      @(negedge clk);
      if (!reset) reset = 1;
      mem_step();
      agents(mode);
      rst_now = 0;
      if (mode == 0 && m_busy && now_edge != m_e0 &&
          ((cyc % 97) == 50 || $urandom_range(0, 30) == 0)) begin
        reset = 0; rst_now = 1;
        m_busy = 0; m_streak = 0;
        f_done = 0; d_done = 0; d_wd = 0;
      end
      #1;
      if (rst_now) check_reset();
      else         check_cycle(mode);
      @(posedge clk);
      if (reset) model_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
